// File: rtl/pipe_stage_skid.sv
// Pipeline register stage with valid/ready handshake, one-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
module pipe_stage_skid #(
   parameter int unsigned PAYLOAD_WIDTH = 147,
   parameter int unsigned CNT_WIDTH     = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [PAYLOAD_WIDTH-1:0] in_data,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [PAYLOAD_WIDTH-1:0] out_data,
   input  logic                     out_ready,
   input  logic                     flush,
   input  logic                     cnt_clear,
   output logic [CNT_WIDTH-1:0]     stall_cnt
);

   localparam logic [CNT_WIDTH-1:0] CntMax = '1;
   localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic                     out_valid_q, out_valid_d;
   logic                     skid_valid_q, skid_valid_d;
   logic [PAYLOAD_WIDTH-1:0] main_q, main_d;
   logic [PAYLOAD_WIDTH-1:0] skid_q, skid_d;
   logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
   logic                     in_fire, out_fire, stalled;

   // in_ready comes straight from a flop: no path from out_ready.
   assign in_ready  = !skid_valid_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;
   assign stall_cnt = cnt_q;

   assign in_fire  = in_valid && !skid_valid_q;
   assign out_fire = out_valid_q && out_ready;
   assign stalled  = out_valid_q && !out_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      main_d       = main_q;
      skid_d       = skid_q;
      if (flush) begin
         // Only the valid bits are cleared; data registers may keep stale values.
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else begin
         case ({out_valid_q, skid_valid_q})
            2'b00: begin
               if (in_fire) begin
                  out_valid_d = 1'b1;
                  main_d      = in_data;
               end
            end
            2'b10: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  skid_valid_d = 1'b1;
                  skid_d       = in_data;
               end else if (out_fire) begin
                  out_valid_d = 1'b0;
               end
            end
            2'b11: begin
               if (out_fire) begin
                  main_d       = skid_q;
                  skid_valid_d = 1'b0;
               end
            end
            default: begin
               out_valid_d  = out_valid_q;
               skid_valid_d = skid_valid_q;
            end
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clear) begin
         cnt_d = '0;
      end else if (stalled && !flush && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + CntOne;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         main_q       <= '0;
         skid_q       <= '0;
         cnt_q        <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         main_q       <= main_d;
         skid_q       <= skid_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed scenario tests plus a randomised handshake soak against a queue model
// for pipe_stage_skid (16-bit payload, 4-bit stall counter).
module tb_pipe_stage_skid;

   localparam int PW = 16;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic [PW-1:0] in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [PW-1:0] out_data;
   logic          out_ready = 1'b0;
   logic          flush = 1'b0;
   logic          cnt_clear = 1'b0;
   logic [CW-1:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   pipe_stage_skid #(
      .PAYLOAD_WIDTH (PW),
      .CNT_WIDTH     (CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .flush     (flush),
      .cnt_clear (cnt_clear),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   // Advance to 1 time unit past the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      checks++;
      if (out_data !== 16'h0) begin
         errors++; $display("FAIL reset_out_data: got %h want 0000", out_data);
      end
      checks++;
      if (stall_cnt !== 4'd0) begin
         errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
      end
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_streaming();
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_data = PW'(i);
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== PW'(i)) begin
            errors++;
            $display("FAIL stream_data[%0d]: got v=%b d=%h want v=1 d=%h",
                     i, out_valid, out_data, PW'(i));
         end
         checks++;
         if (in_ready !== 1'b1) begin
            errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready);
         end
      end
      checks++;
      if (stall_cnt !== 4'd0) begin
         errors++; $display("FAIL stream_stall_cnt: got %0d want 0", stall_cnt);
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL stream_drain: got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      in_valid  = 1'b1;
      in_data   = 16'h000A;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_data   = 16'h000B;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h000A || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_two: got v=%b d=%h rdy=%b want v=1 d=000a rdy=0",
                  out_valid, out_data, in_ready);
      end
      tick();
      checks++;
      if (out_data !== 16'h000A || in_ready !== 1'b0 || stall_cnt !== 4'd2) begin
         errors++;
         $display("FAIL bp_hold: got d=%h rdy=%b cnt=%0d want d=000a rdy=0 cnt=2",
                  out_data, in_ready, stall_cnt);
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h000B || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_second: got v=%b d=%h rdy=%b want v=1 d=000b rdy=1",
                  out_valid, out_data, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || stall_cnt !== 4'd2) begin
         errors++;
         $display("FAIL bp_drain: got v=%b cnt=%0d want v=0 cnt=2", out_valid, stall_cnt);
      end
   endtask

   task automatic test_flush();
      cnt_clear = 1'b1;
      tick();
      cnt_clear = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h000A;
      tick();
      in_data = 16'h000B;
      tick();
      in_data = 16'h000C;
      flush   = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_two: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
      end
      checks++;
      if (stall_cnt !== 4'd1) begin
         errors++; $display("FAIL flush_keeps_cnt: got %0d want 1", stall_cnt);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_leak[%0d]: got v=%b d=%h want v=0", i, out_valid, out_data);
         end
      end
      // Flush in ONE with a same-cycle input: the input must be dropped too.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h00D1;
      tick();
      in_data = 16'h00D2;
      flush   = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_one: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_counter_saturation();
      logic [CW-1:0] exp;
      cnt_clear = 1'b1;
      tick();
      cnt_clear = 1'b0;
      checks++;
      if (stall_cnt !== 4'd0) begin
         errors++; $display("FAIL cnt_clear_initial: got %0d want 0", stall_cnt);
      end
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h00EE;
      tick();
      in_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         exp = (i > 15) ? 4'd15 : CW'(i);
         checks++;
         if (stall_cnt !== exp) begin
            errors++; $display("FAIL cnt_sat[%0d]: got %0d want %0d", i, stall_cnt, exp);
         end
      end
      cnt_clear = 1'b1;
      tick();
      cnt_clear = 1'b0;
      checks++;
      if (stall_cnt !== 4'd0) begin
         errors++; $display("FAIL cnt_clear_prio: got %0d want 0", stall_cnt);
      end
      tick();
      checks++;
      if (stall_cnt !== 4'd1) begin
         errors++; $display("FAIL cnt_resume: got %0d want 1", stall_cnt);
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || stall_cnt !== 4'd1) begin
         errors++;
         $display("FAIL cnt_drain: got v=%b cnt=%0d want v=0 cnt=1", out_valid, stall_cnt);
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h0011;
      tick();
      in_data = 16'h0022;
      tick();
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL arst_setup: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 4'd0 ||
          out_data !== 16'h0) begin
         errors++;
         $display("FAIL arst_immediate: got v=%b rdy=%b cnt=%0d d=%h want v=0 rdy=1 cnt=0 d=0",
                  out_valid, in_ready, stall_cnt, out_data);
      end
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL arst_empty: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
      end
      in_valid = 1'b1;
      in_data  = 16'h0033;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0033) begin
         errors++;
         $display("FAIL arst_first: got v=%b d=%h want v=1 d=0033", out_valid, out_data);
      end
      tick();
   endtask

   task automatic test_soak();
      logic [PW-1:0] q[$];
      int            exp_cnt;
      logic          iv, ordy, ifire, ofire;
      logic [PW-1:0] d;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cnt_clear = 1'b1;
      tick();
      tick();
      cnt_clear = 1'b0;
      exp_cnt   = 0;
      for (int c = 0; c < 10000; c++) begin
         checks++;
         if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
            errors++;
            $display("FAIL soak_state[%0d]: got v=%b rdy=%b want held=%0d",
                     c, out_valid, in_ready, q.size());
         end
         if (q.size() > 0) begin
            checks++;
            if (out_data !== q[0]) begin
               errors++; $display("FAIL soak_data[%0d]: got %h want %h", c, out_data, q[0]);
            end
         end
         checks++;
         if (stall_cnt !== CW'(exp_cnt)) begin
            errors++; $display("FAIL soak_cnt[%0d]: got %0d want %0d", c, stall_cnt, exp_cnt);
         end
         iv   = 1'($urandom_range(1, 0));
         ordy = 1'($urandom_range(1, 0));
         d    = PW'($urandom);
         in_valid  = iv;
         in_data   = d;
         out_ready = ordy;
         ifire = iv && (q.size() < 2);
         ofire = (q.size() > 0) && ordy;
         if ((q.size() > 0) && !ordy && exp_cnt < 15) exp_cnt++;
         tick();
         if (ofire) void'(q.pop_front());
         if (ifire) q.push_back(d);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_counter_saturation();
      test_async_reset();
      test_soak();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline register stage with a full valid/ready handshake, a one-entry skid buffer, synchronous flush and a saturating backpressure counter. It replaces the plain stall/valid-gated stage registers between pipeline stages (decode→execute, execute→memory, …). The payload is an opaque bus of `PAYLOAD_WIDTH` bits. The stage sustains one transfer per cycle with a fully registered `in_ready`, and never drops or duplicates a payload unless flushed.

## Interface
Parameters:
- `PAYLOAD_WIDTH`, default 147: width of the carried bundle. The default is the decode→execute bundle: type 2, pc 32, opcode 7, funct7 7, funct3 3, s1 32, s2 32, immediate 32.
- `CNT_WIDTH`, default 16: width of the stall-cycle counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream holds a valid payload.
- `in_data`  in  PAYLOAD_WIDTH  upstream payload.
- `in_ready`  out  1  stage can accept; registered.
- `out_valid`  out  1  `out_data` is valid.
- `out_data`  out  PAYLOAD_WIDTH  payload to downstream; registered.
- `out_ready`  in  1  downstream accepts this cycle.
- `flush`  in  1  synchronous kill of all held entries and of any same-cycle input.
- `cnt_clear`  in  1  synchronous clear of `stall_cnt`.
- `stall_cnt`  out  CNT_WIDTH  saturating count of cycles with `out_valid && !out_ready`.

## Operation
- An input transfer ("in-fire") occurs when `in_valid && in_ready`. An output transfer ("out-fire") occurs when `out_valid && out_ready`.
- Storage consists of a main register (drives `out_data`) and a skid register (skid_data, skid_valid).
- State is encoded by (out_valid, skid_valid): EMPTY (0,0), ONE (1,0), TWO (1,1). The combination (0,1) is illegal and must never occur.
- `in_ready` = !skid_valid. It is 1 in EMPTY and ONE, and 0 in TWO.
- Transitions when `flush` = 0:
  - EMPTY, in-fire → ONE; main ← `in_data`.
  - ONE, in-fire with out-fire → ONE; main ← `in_data`.
  - ONE, in-fire without out-fire → TWO; skid ← `in_data`; main unchanged.
  - ONE, out-fire without in-fire → EMPTY.
  - TWO, out-fire → ONE; main ← skid. No input is possible in TWO.
  - Any other case: hold state and contents.
- Flush has highest priority. `flush` = 1 forces the next state to EMPTY and discards any same-cycle in-fire. Data registers may hold stale values; only the valid bits are cleared. A same-cycle out-fire still counts as delivered downstream.
- `out_data` is stable while `out_valid && !out_ready`. Payload order is strictly FIFO.
- Stall counter:
  - Increments when `out_valid && !out_ready` and `flush` = 0.
  - Saturates at 2^CNT_WIDTH−1.
  - `cnt_clear` has priority over increment and loads 0.
  - Flush does not clear the counter.

## Timing
- Reset (`rst_n` low, takes effect asynchronously):
  - `out_valid` = 0, skid_valid = 0, `in_ready` = 1.
  - `out_data` = 0, skid_data = 0, `stall_cnt` = 0.
- Reset asserted mid-transfer: all held payloads are lost and there is no partial state. The first edge after release behaves as EMPTY.
- Latency: a payload accepted on edge N is on `out_data` with `out_valid` = 1 immediately after edge N. That is 1 cycle from acceptance to visibility.
- Throughput: 1 payload/cycle while `out_ready` = 1.
- Backpressure reaches upstream one cycle late. The skid register absorbs the single payload accepted in that cycle.
- `in_ready` depends only on registers. There is no combinational path from `out_ready` to `in_ready`.
- `stall_cnt` updates on the same edge as the stall cycle it counts.

## Test plan
- Streaming: after reset, drive payloads 0x1..0x8 with `in_valid` = 1 and `out_ready` = 1 for 8 cycles. Required: `out_data` 0x1..0x8 on consecutive cycles, `in_ready` always 1, `stall_cnt` = 0.
- Backpressure and skid: state ONE holding 0xA. Drop `out_ready` and offer 0xB. Required: state TWO, `in_ready` = 0, `out_data` = 0xA held. Raise `out_ready`. Required: 0xA then 0xB delivered, `in_ready` returns to 1 one cycle after the first out-fire.
- Flush in TWO with concurrent input: hold 0xA and 0xB, assert `flush` while `in_valid` = 1 with 0xC. Required: next cycle `out_valid` = 0 and `in_ready` = 1; 0xA, 0xB and 0xC never appear.
- Counter saturation: `CNT_WIDTH` = 4, hold `out_valid` = 1 and `out_ready` = 0 for 20 cycles. Required: `stall_cnt` = 15 and stays at 15. Pulse `cnt_clear`. Required: `stall_cnt` = 0 next cycle, then counting resumes.
- Async reset mid-operation: in TWO, drop `rst_n` between clock edges. Required: `out_valid` = 0, `in_ready` = 1 and `stall_cnt` = 0 immediately, without waiting for an edge.
- Random handshake soak: random `in_valid` and `out_ready`, 10k cycles. Required: output sequence equals the accepted input sequence, no (0,1) state, `out_data` stable while stalled.
